ps2_key_decoder: RTL and testbench

Consumes raw PS/2 set-2 scan-code bytes from the keyboard receiver FIFO and turns them into key events. Resolves `E0` (extended) and `F0` (break) prefixes, tracks Shift and Caps Lock, and maps make codes to ASCII. Counts distinct key presses, ignoring typematic auto-repeat. Sits directly downstream of the receiver FIFO (its `ready`/`nextdate_n` pop interface) and upstream of display and console logic.

---
 rtl/ps2_pkg.sv | 37 +++
 rtl/ps2_ascii_map.sv | 81 ++++++++
 rtl/ps2_key_decoder.sv | 115 +++++++++++
 tb/tb_ps2_key_decoder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, FSM state type and digit-row helper for the
// PS/2 set-2 key decoder.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_SPACE  = 8'h29;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        DECODE = 2'd2
    } state_t;

    // US layout symbols above the digit row, indexed by digit value.
    function automatic logic [7:0] shifted_digit(input logic [3:0] digit);
        logic [7:0] sym;
        case (digit)
            4'd0:    sym = 8'h29;
            4'd1:    sym = 8'h21;
            4'd2:    sym = 8'h40;
            4'd3:    sym = 8'h23;
            4'd4:    sym = 8'h24;
            4'd5:    sym = 8'h25;
            4'd6:    sym = 8'h5E;
            4'd7:    sym = 8'h26;
            4'd8:    sym = 8'h2A;
            4'd9:    sym = 8'h28;
            default: sym = 8'h00;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/ps2_ascii_map.sv
// Combinational set-2 make-code to ASCII translation for letters, the digit
// row and space; everything else maps to 0.
module ps2_ascii_map
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [7:0] letter;
    logic       is_letter;
    logic [3:0] digit;
    logic       is_digit;

    always_comb begin
        is_letter = 1'b1;
        letter    = 8'h00;
        case (code)
            8'h1C: letter = 8'h41;
            8'h32: letter = 8'h42;
            8'h21: letter = 8'h43;
            8'h23: letter = 8'h44;
            8'h24: letter = 8'h45;
            8'h2B: letter = 8'h46;
            8'h34: letter = 8'h47;
            8'h33: letter = 8'h48;
            8'h43: letter = 8'h49;
            8'h3B: letter = 8'h4A;
            8'h42: letter = 8'h4B;
            8'h4B: letter = 8'h4C;
            8'h3A: letter = 8'h4D;
            8'h31: letter = 8'h4E;
            8'h44: letter = 8'h4F;
            8'h4D: letter = 8'h50;
            8'h15: letter = 8'h51;
            8'h2D: letter = 8'h52;
            8'h1B: letter = 8'h53;
            8'h2C: letter = 8'h54;
            8'h3C: letter = 8'h55;
            8'h2A: letter = 8'h56;
            8'h1D: letter = 8'h57;
            8'h22: letter = 8'h58;
            8'h35: letter = 8'h59;
            8'h1A: letter = 8'h5A;
            default: is_letter = 1'b0;
        endcase
    end

    always_comb begin
        is_digit = 1'b1;
        digit    = 4'd0;
        case (code)
            8'h45: digit = 4'd0;
            8'h16: digit = 4'd1;
            8'h1E: digit = 4'd2;
            8'h26: digit = 4'd3;
            8'h25: digit = 4'd4;
            8'h2E: digit = 4'd5;
            8'h36: digit = 4'd6;
            8'h3D: digit = 4'd7;
            8'h3E: digit = 4'd8;
            8'h46: digit = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

    // Caps Lock only affects letters; the digit row follows Shift alone.
    always_comb begin
        ascii = 8'h00;
        if (is_letter) begin
            ascii = (shift ^ caps) ? letter : letter + 8'h20;
        end else if (is_digit) begin
            ascii = shift ? shifted_digit(digit) : 8'h30 + {4'h0, digit};
        end else if (code == SC_SPACE) begin
            ascii = 8'h20;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Pops scan-code bytes from the receiver FIFO, resolves E0/F0 prefixes and
// emits key events with ASCII, modifier state and a distinct-press counter.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrk,
    input  logic             ready,
    input  logic [7:0]       date,
    output logic             nextdate_n,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_brk,
    output logic [7:0]       ascii,
    output logic             shift,
    output logic             caps,
    output logic [CNT_W-1:0] press_count
);

    state_t     state;
    logic [7:0] byte_r;
    logic       ext_p;
    logic       brk_p;
    logic       shl;
    logic       shr;
    logic       held_v;
    logic [7:0] held_code;
    logic       held_ext;
    logic       is_held;
    logic [7:0] map_ascii;

    assign shift   = shl | shr;
    assign is_held = held_v && (held_code == byte_r) && (held_ext == ext_p);

    // Fed the pre-event modifier state so a Shift make never affects itself.
    ps2_ascii_map u_ascii_map (
        .code  (byte_r),
        .shift (shift),
        .caps  (caps),
        .ascii (map_ascii)
    );

    always_ff @(posedge clk) begin
        if (clrk) begin
            state       <= IDLE;
            byte_r      <= 8'h00;
            nextdate_n  <= 1'b1;
            key_valid   <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_brk     <= 1'b0;
            ascii       <= 8'h00;
            ext_p       <= 1'b0;
            brk_p       <= 1'b0;
            shl         <= 1'b0;
            shr         <= 1'b0;
            caps        <= 1'b0;
            held_v      <= 1'b0;
            held_code   <= 8'h00;
            held_ext    <= 1'b0;
            press_count <= '0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ready) begin
                        byte_r     <= date;
                        nextdate_n <= 1'b0;
                        state      <= POP;
                    end
                end
                POP: begin
                    nextdate_n <= 1'b1;
                    state      <= DECODE;
                end
                DECODE: begin
                    state <= IDLE;
                    if (byte_r == SC_EXT) begin
                        ext_p <= 1'b1;
                    end else if (byte_r == SC_BRK) begin
                        brk_p <= 1'b1;
                    end else begin
                        key_valid <= 1'b1;
                        key_code  <= byte_r;
                        key_ext   <= ext_p;
                        key_brk   <= brk_p;
                        ascii     <= (ext_p || brk_p) ? 8'h00 : map_ascii;
                        ext_p     <= 1'b0;
                        brk_p     <= 1'b0;
                        if (!ext_p && byte_r == SC_LSHIFT) shl <= !brk_p;
                        if (!ext_p && byte_r == SC_RSHIFT) shr <= !brk_p;
                        // A make of the key already held is typematic repeat.
                        if (!brk_p) begin
                            if (!is_held) press_count <= press_count + CNT_W'(1);
                            if (!ext_p && byte_r == SC_CAPS && !is_held) caps <= !caps;
                            held_v    <= 1'b1;
                            held_code <= byte_r;
                            held_ext  <= ext_p;
                        end else if (is_held) begin
                            held_v <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    nextdate_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: a keyboard-level model predicts each
// key event, and a monitor compares whatever the decoder emits against it.
module tb_ps2_key_decoder;

    localparam int CNT_W = 8;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] asc;
        logic       shift;
        logic       caps;
        logic [7:0] count;
    } event_t;

    logic             clk = 1'b0;
    logic             clrk = 1'b1;
    logic             ready = 1'b0;
    logic [7:0]       date = 8'h00;
    logic             nextdate_n;
    logic             key_valid;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_brk;
    logic [7:0]       ascii;
    logic             shift;
    logic             caps;
    logic [CNT_W-1:0] press_count;

    int nChecks = 0;
    int nFails  = 0;

    logic [7:0] fifo[$];
    event_t     expQ[$];

    // Keyboard-level model state
    bit         mExt, mBrk, mLeftShift, mRightShift, mCaps, mHeld, mHeldExt;
    logic [7:0] mHeldCode;
    int         mPresses;

    string      letters       = "abcdefghijklmnopqrstuvwxyz";
    string      digitSymbols  = ")!@#$%^&*(";
    logic [7:0] letterCodes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                    8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digitCodes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                   8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    ps2_key_decoder #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .clrk        (clrk),
        .ready       (ready),
        .date        (date),
        .nextdate_n  (nextdate_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_brk     (key_brk),
        .ascii       (ascii),
        .shift       (shift),
        .caps        (caps),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] modelAscii(input logic [7:0] code, input bit sh, input bit cl);
        for (int i = 0; i < 26; i++)
            if (code == letterCodes[i])
                return (sh ^ cl) ? 8'(letters[i]) - 8'h20 : 8'(letters[i]);
        for (int i = 0; i < 10; i++)
            if (code == digitCodes[i])
                return sh ? 8'(digitSymbols[i]) : 8'h30 + 8'(i);
        if (code == 8'h29) return 8'h20;
        return 8'h00;
    endfunction

    function automatic void modelReset();
        mExt = 0; mBrk = 0; mLeftShift = 0; mRightShift = 0; mCaps = 0;
        mHeld = 0; mHeldExt = 0; mHeldCode = 8'h00; mPresses = 0;
    endfunction

    function automatic void modelByte(input logic [7:0] b);
        event_t e;
        bit     sameKey;
        if (b == 8'hE0) begin
            mExt = 1;
        end else if (b == 8'hF0) begin
            mBrk = 1;
        end else begin
            e.code  = b;
            e.ext   = mExt;
            e.brk   = mBrk;
            e.asc   = (mExt || mBrk) ? 8'h00 : modelAscii(b, mLeftShift | mRightShift, mCaps);
            sameKey = mHeld && (mHeldCode == b) && (mHeldExt == mExt);
            if (!mExt && b == 8'h12) mLeftShift  = !mBrk;
            if (!mExt && b == 8'h59) mRightShift = !mBrk;
            if (!mBrk) begin
                if (!sameKey) mPresses = (mPresses + 1) % (1 << CNT_W);
                if (!mExt && b == 8'h58 && !sameKey) mCaps = !mCaps;
                mHeld = 1; mHeldCode = b; mHeldExt = mExt;
            end else if (sameKey) begin
                mHeld = 0;
            end
            e.shift = mLeftShift | mRightShift;
            e.caps  = mCaps;
            e.count = 8'(mPresses);
            expQ.push_back(e);
            mExt = 0;
            mBrk = 0;
        end
    endfunction

    task automatic applyStimulus(input logic [7:0] b);
        modelByte(b);
        fifo.push_back(b);
    endtask

    // Registered FIFO model: a pop strobe seen in a cycle takes effect at its closing edge.
    initial begin
        bit popNow;
        forever begin
            @(negedge clk);
            popNow = (nextdate_n == 1'b0);
            @(posedge clk);
            #1;
            if (popNow && fifo.size() > 0) void'(fifo.pop_front());
            ready = (fifo.size() > 0);
            date  = ready ? fifo[0] : 8'h00;
        end
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected event: got code %0h ext %0b brk %0b, expected no event",
                         key_code, key_ext, key_brk);
            end else begin
                event_t e;
                e = expQ.pop_front();
                checkOutput("key_code", 32'(key_code), 32'(e.code));
                checkOutput("key_ext", 32'(key_ext), 32'(e.ext));
                checkOutput("key_brk", 32'(key_brk), 32'(e.brk));
                checkOutput("ascii", 32'(ascii), 32'(e.asc));
                checkOutput("shift", 32'(shift), 32'(e.shift));
                checkOutput("caps", 32'(caps), 32'(e.caps));
                checkOutput("press_count", 32'(press_count), 32'(e.count));
            end
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " nextdate_n"}, 32'(nextdate_n), 32'd1);
        checkOutput({tag, " key_valid"}, 32'(key_valid), 32'd0);
        checkOutput({tag, " key_code"}, 32'(key_code), 32'd0);
        checkOutput({tag, " key_ext"}, 32'(key_ext), 32'd0);
        checkOutput({tag, " key_brk"}, 32'(key_brk), 32'd0);
        checkOutput({tag, " ascii"}, 32'(ascii), 32'd0);
        checkOutput({tag, " shift"}, 32'(shift), 32'd0);
        checkOutput({tag, " caps"}, 32'(caps), 32'd0);
        checkOutput({tag, " press_count"}, 32'(press_count), 32'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        clrk = 1'b1;
        fifo.delete();
        expQ.delete();
        modelReset();
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        clrk = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int cycles = 0;
        while ((fifo.size() > 0 || expQ.size() > 0) && cycles < 5000) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 5000) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL %s drain: got %0d bytes and %0d events pending, expected 0",
                     tag, fifo.size(), expQ.size());
        end
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [7:0] randomByte(input logic [7:0] last);
        int r = $urandom_range(0, 99);
        if (r < 10) return 8'hE0;
        if (r < 22) return 8'hF0;
        if (r < 30) return ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
        if (r < 34) return 8'h58;
        if (r < 40) return 8'h29;
        if (r < 70) return letterCodes[$urandom_range(0, 25)];
        if (r < 85) return digitCodes[$urandom_range(0, 9)];
        if (r < 92) return last;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        logic [7:0] seq2[6] = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12};
        logic [7:0] seq3[4] = '{8'h58, 8'h1C, 8'h12, 8'h1C};
        logic [7:0] seq4[7] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C, 8'hF0};
        logic [7:0] seq5[5] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        logic [7:0] lastByte = 8'h1C;
        int         waitCycles;

        modelReset();
        doReset();

        // Single make: pop and event latency relative to ready
        applyStimulus(8'h1C);
        @(posedge clk);
        #2;
        @(negedge clk);
        checkOutput("pop not before ready", 32'(nextdate_n), 32'd1);
        @(negedge clk);
        checkOutput("pop one cycle after ready", 32'(nextdate_n), 32'd0);
        @(negedge clk);
        checkOutput("no event in decode cycle", 32'(key_valid), 32'd0);
        @(negedge clk);
        checkOutput("event three cycles after ready", 32'(key_valid), 32'd1);
        waitDrain("single make");
        checkOutput("single make press_count", 32'(press_count), 32'd1);

        doReset();
        foreach (seq2[i]) applyStimulus(seq2[i]);
        waitDrain("shift sequence");
        checkOutput("shift released", 32'(shift), 32'd0);
        checkOutput("shift sequence press_count", 32'(press_count), 32'd2);

        doReset();
        foreach (seq3[i]) applyStimulus(seq3[i]);
        waitDrain("caps sequence");
        checkOutput("caps on", 32'(caps), 32'd1);
        checkOutput("caps plus shift ascii", 32'(ascii), 32'h61);

        doReset();
        foreach (seq4[i]) applyStimulus(seq4[i]);
        waitDrain("typematic");
        checkOutput("typematic press_count", 32'(press_count), 32'd2);

        doReset();
        foreach (seq5[i]) applyStimulus(seq5[i]);
        waitDrain("extended");
        checkOutput("extended press_count", 32'(press_count), 32'd1);
        checkOutput("extended last brk", 32'(key_brk), 32'd1);

        // Reset landing in POP drops the byte being popped
        doReset();
        fifo.push_back(8'h1C);
        applyStimulus(8'h24);
        waitCycles = 0;
        do begin
            @(negedge clk);
            waitCycles++;
        end while (nextdate_n !== 1'b0 && waitCycles < 20);
        checkOutput("pop reached before abort", 32'(nextdate_n), 32'd0);
        clrk = 1'b1;
        @(negedge clk);
        checkResetValues("abort");
        clrk = 1'b0;
        @(negedge clk);
        checkOutput("pop resumes after abort", 32'(nextdate_n), 32'd0);
        waitDrain("abort");
        checkOutput("abort press_count", 32'(press_count), 32'd1);

        // Randomized key traffic against the model
        doReset();
        for (int i = 0; i < 400; i++) begin
            lastByte = randomByte(lastByte);
            applyStimulus(lastByte);
        end
        waitDrain("random");
        checkOutput("random final shift", 32'(shift), 32'(mLeftShift | mRightShift));
        checkOutput("random final caps", 32'(caps), 32'(mCaps));
        checkOutput("random final press_count", 32'(press_count), 32'(mPresses));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
